sprite_line_scheduler: RTL and testbench
========================================

# sprite_line_scheduler

Schedules the shared single-port sprite ROM across six on-screen objects (player plus five enemies), one scanline ahead of the beam. At each line start it swaps a double-buffered bank of per-object row bitmaps, then fetches the next line's rows into the shadow bank on a fixed seven-cycle schedule. Its pixel outputs replace per-pixel ROM addressing in the color mapper, which then only chooses between text, sprite and background colors.

## Interface
Parameters:
- `NUM_OBJ`, default 6. Object slots; slot 0 is the player.
- `SPR_W`, default 32. Sprite width and height in pixels.

Ports:
- `Clk`, in, 1. System clock.
- `Reset`, in, 1. Asynchronous, active-high reset.
- `line_start`, in, 1. One-cycle pulse at the start of horizontal blank.
- `fetch_y`, in, 10. Scanline to prefetch; sampled on `line_start`.
- `DrawX`, in, 10. Current pixel column.
- `obj_en`, in, NUM_OBJ. Per-object enable.
- `obj_x`, in, 10·NUM_OBJ. Packed X positions; slot k occupies bits [10k+9:10k].
- `obj_y`, in, 10·NUM_OBJ. Packed Y positions, same packing as `obj_x`.
- `obj_base`, in, 7·NUM_OBJ. ROM base row address per object.
- `rom_addr`, out, 7. Sprite ROM address.
- `rom_data`, in, 32. Sprite ROM row. Valid one cycle after `rom_addr`, because the ROM is synchronous.
- `busy`, out, 1. High while a fetch is in progress.
- `fetch_done`, out, 1. One-cycle pulse after the last capture.
- `overrun`, out, 1. One-cycle pulse when `line_start` arrives while `busy`.
- `sprite_hit`, out, 1. The current pixel is an opaque sprite pixel.
- `sprite_id`, out, 3. Winning slot index; 0 when there is no hit.

## Operation
- Two banks. Each slot holds `row` (32 bits), `x` (10 bits) and `valid`. The `bank_sel` bit selects the active (displayed) bank; the other bank is the shadow (being filled).
- FSM states are IDLE, FETCH and LAST.
- IDLE → FETCH on `line_start`. In the same edge:
  - toggle `bank_sel`;
  - latch `fetch_y`;
  - clear all shadow `valid` bits;
  - set `idx` to 0.
- FETCH with `idx` = k:
  - Vertical-visibility test: `obj_en[k]` and `fetch_y` ≥ `obj_y[k]` and `fetch_y` < `obj_y[k]` + SPR_W.
  - All comparisons use 11-bit zero-extended arithmetic, so Y = 1000 never wraps.
  - If visible: `rom_addr` = `obj_base[k]` + (`fetch_y` − `obj_y[k]`)[4:0], mod 128. Otherwise `rom_addr` = 0.
  - The per-slot visibility flag and `obj_x[k]` are registered into a capture pipeline.
  - `idx` increments. After k = NUM_OBJ−1, the FSM goes to LAST.
- Capture: in the cycle after the address for slot k is issued:
  - shadow `row[k]` ← `rom_data`;
  - shadow `x[k]` ← captured X;
  - shadow `valid[k]` ← captured visibility.
  - Invisible slots still consume their cycle (fixed schedule), with `valid` = 0.
- LAST captures slot NUM_OBJ−1, then returns to IDLE and asserts `fetch_done` in the next cycle.
- `line_start` while in FETCH or LAST:
  - pulse `overrun`;
  - perform a normal swap and restart at `idx` 0.
  - Slots not yet captured stay invalid, so a partially filled bank displays with missing sprites only.
- Pixel path, combinational from the active bank:
  - Slot k hits if `valid[k]`, 11-bit `DrawX` ≥ `x[k]`, `DrawX` < `x[k]` + SPR_W, and `row[k]`[`DrawX` − `x[k]`].
  - The lowest hitting index wins and sets `sprite_id`. `sprite_hit` is the OR of all slot hits.
- Object inputs are sampled per slot during its FETCH cycle. They must be stable during blank.

## Timing
- `line_start` high in cycle T:
  - swap visible from T+1;
  - `busy` = 1 during T+1 … T+7;
  - `rom_addr` for slot k is driven in cycle T+1+k;
  - data for slot k is captured at the end of T+2+k;
  - `fetch_done` = 1 in T+8.
- Fetch latency is NUM_OBJ+1 cycles. The next-line fetch must finish before the next `line_start`.
- Reset values:
  - state IDLE, `bank_sel` 0, `idx` 0;
  - all `valid` 0, all `row` and `x` 0;
  - `rom_addr` 0, `busy` 0, `fetch_done` 0, `overrun` 0;
  - `sprite_hit` 0, `sprite_id` 0.
- Reset asserted mid-fetch forces the reset values immediately, with no further captures.
- `line_start` during reset is ignored.

## Test plan
- **Single object.** Slot 0 at (100,50), base 64, ROM row 68 = 32'h0000_0001, `line_start` with `fetch_y` = 54. Required:
  - `rom_addr` = 68 at T+1, `fetch_done` at T+8;
  - after the next swap, `DrawX` = 100 gives hit with id 0, and `DrawX` = 101 gives no hit.
- **Overlap priority.** Slots 0 and 3 at the same position, both rows all-ones. Required: hit with id 0. With `obj_en[0]` = 0: id 3.
- **Vertical boundaries.** `obj_y` = 50: `fetch_y` 49 → valid 0; `fetch_y` 81 → row 31 fetched; `fetch_y` 82 → valid 0. With `obj_y` = 1000 and `fetch_y` = 5: no wrap hit.
- **Horizontal boundaries.** `x` = 620: `DrawX` 651 → bit 31 used; `DrawX` 652 → no hit; `DrawX` 619 → no hit.
- **Overrun.** Second `line_start` at T+4. Required:
  - `overrun` pulse at T+5;
  - slots 0–2 of the new active bank valid per visibility, slots 3–5 invalid;
  - fetch restarts with `idx` 0 at T+5.
- **Async reset mid-fetch.** `Reset` asserted at T+3, mid-cycle. Required: `busy`, `rom_addr` and `sprite_hit` go to 0 without waiting for a clock edge, and the next fetch after release works normally.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Prefetches one scanline of sprite rows per object from a shared synchronous ROM into a
// double-buffered bank, then resolves per-pixel sprite hits from the displayed bank.
module sprite_line_scheduler #(
  parameter int NUM_OBJ = 6,
  parameter int SPR_W   = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  line_start,
  input  logic [9:0]            fetch_y,
  input  logic [9:0]            DrawX,
  input  logic [NUM_OBJ-1:0]    obj_en,
  input  logic [10*NUM_OBJ-1:0] obj_x,
  input  logic [10*NUM_OBJ-1:0] obj_y,
  input  logic [7*NUM_OBJ-1:0]  obj_base,
  output logic [6:0]            rom_addr,
  input  logic [31:0]           rom_data,
  output logic                  busy,
  output logic                  fetch_done,
  output logic                  overrun,
  output logic                  sprite_hit,
  output logic [2:0]            sprite_id
);
  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int OFF_W = $clog2(SPR_W);
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               bank_sel_reg;
  logic [9:0]         fy_reg;
  logic               cap_pend_reg, cap_vis_reg;
  logic [9:0]         cap_x_reg;
  logic [IDX_W-1:0]   cap_idx_reg;
  logic               fetch_done_reg, overrun_reg;
  logic               swap, issue;

  logic [31:0]        row_reg   [2][NUM_OBJ];
  logic [9:0]         x_reg     [2][NUM_OBJ];
  logic [NUM_OBJ-1:0] valid_reg [2];

  logic [SLOTS-1:0]   vis_all;
  logic [6:0]         addr_all [SLOTS];
  logic [9:0]         x_all    [SLOTS];
  logic [NUM_OBJ-1:0] hit;
  logic [10:0]        fy_ext, dx_ext;

  assign fy_ext = {1'b0, fy_reg};
  assign dx_ext = {1'b0, DrawX};

  // Per-slot vertical test and ROM row address; padded to a power of two for idx muxing.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < NUM_OBJ) begin : g_obj
      logic [10:0]      oy_ext;
      logic [OFF_W-1:0] dy;
      assign oy_ext       = {1'b0, obj_y[10*gi +: 10]};
      assign dy           = fy_reg[OFF_W-1:0] - obj_y[10*gi +: OFF_W];
      assign vis_all[gi]  = obj_en[gi] && (fy_ext >= oy_ext) && (fy_ext < oy_ext + 11'(SPR_W));
      assign addr_all[gi] = obj_base[7*gi +: 7] + 7'(dy);
      assign x_all[gi]    = obj_x[10*gi +: 10];
    end else begin : g_pad
      assign vis_all[gi]  = 1'b0;
      assign addr_all[gi] = '0;
      assign x_all[gi]    = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    swap       = 1'b0;
    issue      = 1'b0;
    busy       = 1'b0;
    rom_addr   = '0;
    case (state_reg)
      IDLE: ;
      FETCH: begin
        busy     = 1'b1;
        issue    = 1'b1;
        rom_addr = vis_all[idx_reg] ? addr_all[idx_reg] : 7'd0;
        if (idx_reg == LAST_IDX) begin
          state_next = LAST;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      LAST: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A new line always wins: swap banks and restart, even mid-fetch.
    if (line_start) begin
      swap       = 1'b1;
      state_next = FETCH;
      idx_next   = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bank_sel_reg   <= 1'b0;
      fy_reg         <= '0;
      cap_pend_reg   <= 1'b0;
      cap_vis_reg    <= 1'b0;
      cap_x_reg      <= '0;
      cap_idx_reg    <= '0;
      fetch_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        valid_reg[b] <= '0;
        for (int k = 0; k < NUM_OBJ; k++) begin
          row_reg[b][k] <= '0;
          x_reg[b][k]   <= '0;
        end
      end
    end else begin
      fetch_done_reg <= (state_reg == LAST) && !line_start;
      overrun_reg    <= line_start && (state_reg != IDLE);
      // A capture still in flight at a swap is dropped so it cannot land in the new shadow bank.
      cap_pend_reg   <= issue && !swap;
      cap_vis_reg    <= vis_all[idx_reg];
      cap_x_reg      <= x_all[idx_reg];
      cap_idx_reg    <= idx_reg;
      if (cap_pend_reg) begin
        for (int k = 0; k < NUM_OBJ; k++) begin
          if (cap_idx_reg == IDX_W'(k)) begin
            row_reg[!bank_sel_reg][k]   <= rom_data;
            x_reg[!bank_sel_reg][k]     <= cap_x_reg;
            valid_reg[!bank_sel_reg][k] <= cap_vis_reg;
          end
        end
      end
      if (swap) begin
        bank_sel_reg            <= !bank_sel_reg;
        fy_reg                  <= fetch_y;
        valid_reg[bank_sel_reg] <= '0;
      end
    end
  end

  // Pixel path from the displayed bank; row bit index wraps naturally within the sprite width.
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_hit
    logic [10:0]      sx_ext;
    logic [OFF_W-1:0] rel;
    assign sx_ext  = {1'b0, x_reg[bank_sel_reg][gi]};
    assign rel     = DrawX[OFF_W-1:0] - x_reg[bank_sel_reg][gi][OFF_W-1:0];
    assign hit[gi] = valid_reg[bank_sel_reg][gi] && (dx_ext >= sx_ext) &&
                     (dx_ext < sx_ext + 11'(SPR_W)) && row_reg[bank_sel_reg][gi][rel];
  end

  always_comb begin
    sprite_id = 3'd0;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (hit[k]) sprite_id = 3'(k);
    end
  end

  assign sprite_hit = |hit;
  assign fetch_done = fetch_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: a line-level model of the banked prefetch and pixel
// priority is compared every cycle, alongside directed literal checks and random lines.
`timescale 1ns/1ps
module tb_sprite_line_scheduler;
  localparam int N = 6;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            line_start = 1'b0;
  logic [9:0]      fetch_y = '0;
  logic [9:0]      DrawX = '0;
  logic [N-1:0]    obj_en = '0;
  logic [10*N-1:0] obj_x = '0;
  logic [10*N-1:0] obj_y = '0;
  logic [7*N-1:0]  obj_base = '0;
  logic [6:0]      rom_addr;
  logic [31:0]     rom_data = '0;
  logic            busy, fetch_done, overrun, sprite_hit;
  logic [2:0]      sprite_id;

  logic [31:0] rom [128];
  int vectors = 0;
  int miscompares = 0;

  sprite_line_scheduler #(.NUM_OBJ(N), .SPR_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .fetch_y(fetch_y), .DrawX(DrawX),
    .obj_en(obj_en), .obj_x(obj_x), .obj_y(obj_y), .obj_base(obj_base),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .fetch_done(fetch_done),
    .overrun(overrun), .sprite_hit(sprite_hit), .sprite_id(sprite_id)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM: data one cycle after the address.
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- line-level model ----------------
  typedef struct {
    bit          v;
    logic [31:0] row;
    int          x;
    int          addr;
  } slot_t;

  slot_t act [N];
  slot_t pend [N];
  bit inprog = 1'b0;
  int cyc = 0, t0 = 0, ovr_cyc = -1, done_cyc = -1;

  function automatic slot_t plan(int k);
    slot_t s;
    int fy, oy;
    fy     = int'(fetch_y);
    oy     = int'(obj_y[10*k +: 10]);
    s.v    = obj_en[k] && (fy >= oy) && (fy < oy + 32);
    s.addr = s.v ? (int'(obj_base[7*k +: 7]) + (fy - oy)) % 128 : 0;
    s.row  = rom[s.addr];
    s.x    = int'(obj_x[10*k +: 10]);
    return s;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inprog   = 1'b0;
      ovr_cyc  = -1;
      done_cyc = -1;
      for (int k = 0; k < N; k++) begin
        act[k]  = '{v: 1'b0, row: 32'd0, x: 0, addr: 0};
        pend[k] = '{v: 1'b0, row: 32'd0, x: 0, addr: 0};
      end
    end else begin
      if (line_start) begin
        int n;
        // slots whose capture edge has already passed survive into the displayed bank
        n = inprog ? cyc - t0 - 1 : N;
        if (n > N) n = N;
        if (n < 0) n = 0;
        for (int k = 0; k < N; k++) begin
          act[k] = pend[k];
          if (k >= n) act[k].v = 1'b0;
        end
        ovr_cyc  = inprog ? cyc + 1 : -1;
        done_cyc = cyc + N + 2;
        t0       = cyc;
        inprog   = 1'b1;
        for (int k = 0; k < N; k++) pend[k] = plan(k);
      end else if (inprog && cyc == t0 + N + 1) begin
        inprog = 1'b0;
      end
      cyc++;
    end
  end

  always @(negedge Clk) begin
    logic [13:0] got, exp;
    bit eh;
    int eid, ea, dx;
    eh  = 1'b0;
    eid = 0;
    dx  = int'(DrawX);
    for (int k = 0; k < N; k++) begin
      if (!eh && act[k].v && dx >= act[k].x && dx < act[k].x + 32 && act[k].row[dx - act[k].x]) begin
        eh  = 1'b1;
        eid = k;
      end
    end
    ea  = (inprog && cyc <= t0 + N) ? pend[cyc - t0 - 1].addr : 0;
    exp = {inprog, 7'(ea), (cyc == done_cyc), (cyc == ovr_cyc), eh, 3'(eid)};
    got = {busy, rom_addr, fetch_done, overrun, sprite_hit, sprite_id};
    check("cycle{busy,addr,done,ovr,hit,id}", 32'(got), 32'(exp));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_obj(int k, bit en, int x, int y, int base);
    obj_en[k]            = en;
    obj_x[10*k +: 10]    = 10'(x);
    obj_y[10*k +: 10]    = 10'(y);
    obj_base[7*k +: 7]   = 7'(base);
  endtask

  task automatic fetch(int fy, int exp_addr, string name);
    fetch_y    = 10'(fy);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    @(negedge Clk);
    $display("fetch %s: fetch_y=%0d slot0 rom_addr=%0d", name, fy, rom_addr);
    check(name, 32'(rom_addr), 32'(exp_addr));
    repeat (9) tick();
  endtask

  // The second line start puts the first fetch on display.
  task automatic show(int fy, int exp_addr, string name);
    fetch(fy, exp_addr, name);
    fetch(fy, exp_addr, name);
  endtask

  task automatic pix(int dx, bit eh, int eid, string name);
    DrawX = 10'(dx);
    @(negedge Clk);
    $display("pixel %s: DrawX=%0d hit=%0d id=%0d", name, dx, sprite_hit, sprite_id);
    check(name, 32'({sprite_hit, sprite_id}), 32'({eh, 3'(eid)}));
    tick();
  endtask

  initial begin
    int scene;
    scene = 300;
    for (int a = 0; a < 128; a++) rom[a] = $urandom;
    repeat (3) tick();
    @(negedge Clk);
    check("reset_outputs", 32'({busy, rom_addr, fetch_done, overrun, sprite_hit, sprite_id}), 32'd0);
    tick();
    Reset = 1'b0;
    tick();

    // single object
    set_obj(0, 1'b1, 100, 50, 64);
    rom[68] = 32'h0000_0001;
    fetch_y    = 10'd54;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    @(negedge Clk);
    check("single_addr_T1", 32'(rom_addr), 32'd68);
    repeat (7) @(posedge Clk);
    @(negedge Clk);
    check("single_done_T8", 32'(fetch_done), 32'd1);
    tick();
    tick();
    fetch(54, 68, "single_swap");
    pix(100, 1'b1, 0, "single_x100");
    pix(101, 1'b0, 0, "single_x101");
    pix(99,  1'b0, 0, "single_x99");

    // overlap priority
    set_obj(0, 1'b1, 200, 100, 10);
    set_obj(3, 1'b1, 200, 100, 20);
    rom[10] = 32'hFFFF_FFFF;
    rom[20] = 32'hFFFF_FFFF;
    show(100, 10, "overlap");
    pix(210, 1'b1, 0, "overlap_id0");
    obj_en[0] = 1'b0;
    show(100, 0, "overlap_en0_off");
    pix(210, 1'b1, 3, "overlap_id3");
    obj_en = '0;

    // vertical boundaries
    rom[0]  = 32'hFFFF_FFFF;
    rom[31] = 32'hFFFF_FFFF;
    set_obj(0, 1'b1, 300, 50, 0);
    show(49, 0, "vert_y49");
    pix(310, 1'b0, 0, "vert_y49_pix");
    show(81, 31, "vert_y81");
    pix(310, 1'b1, 0, "vert_y81_pix");
    show(82, 0, "vert_y82");
    pix(310, 1'b0, 0, "vert_y82_pix");
    set_obj(0, 1'b1, 300, 1000, 0);
    show(5, 0, "vert_nowrap");
    pix(310, 1'b0, 0, "vert_nowrap_pix");

    // horizontal boundaries
    set_obj(0, 1'b1, 620, 50, 40);
    rom[40] = 32'h8000_0000;
    show(50, 40, "horiz");
    pix(651, 1'b1, 0, "horiz_651");
    pix(650, 1'b0, 0, "horiz_650");
    pix(652, 1'b0, 0, "horiz_652");
    pix(619, 1'b0, 0, "horiz_619");

    // overrun: second line start at T+4
    for (int k = 0; k < N; k++) begin
      set_obj(k, 1'b1, 40 * k, 50, 60 + k);
      rom[60 + k] = 32'hFFFF_FFFF;
    end
    fetch_y    = 10'd50;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (3) tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    @(negedge Clk);
    check("overrun_pulse_T5", 32'(overrun), 32'd1);
    check("overrun_restart_addr", 32'(rom_addr), 32'd60);
    tick();
    for (int k = 0; k < N; k++) pix(40 * k + 5, k < 3, (k < 3) ? k : 0, $sformatf("overrun_slot%0d", k));
    repeat (10) tick();

    // asynchronous reset mid-fetch
    DrawX      = 10'd5;
    fetch_y    = 10'd50;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_addr", 32'(rom_addr), 32'd62);
    check("pre_reset_hit", 32'(sprite_hit), 32'd1);
    Reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_addr", 32'(rom_addr), 32'd0);
    check("async_hit", 32'(sprite_hit), 32'd0);
    line_start = 1'b1;
    tick();
    tick();
    line_start = 1'b0;
    Reset      = 1'b0;
    tick();
    @(negedge Clk);
    check("post_reset_idle", 32'(busy), 32'd0);
    tick();
    show(50, 60, "post_reset");
    pix(5, 1'b1, 0, "post_reset_slot0");
    pix(45, 1'b1, 1, "post_reset_slot1");

    // randomized lines; object inputs only change while no fetch is running
    for (int i = 0; i < 3000; i++) begin
      DrawX = 10'($urandom_range(0, 700));
      if (!inprog && $urandom_range(0, 3) == 0) begin
        scene = $urandom_range(40, 520);
        for (int k = 0; k < N; k++)
          set_obj(k, $urandom_range(0, 3) != 0, $urandom_range(0, 639),
                  scene - $urandom_range(0, 40), $urandom_range(0, 127));
        if ($urandom_range(0, 7) == 0) obj_y[10*$urandom_range(0, N-1) +: 10] = 10'd1000;
      end
      line_start = ($urandom_range(0, 7) == 0);
      fetch_y    = 10'(scene + $urandom_range(0, 4) - 2);
      tick();
    end
    line_start = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
